// File: rtl/sha256_pkg.sv
// sha256_pkg
// Shared definitions for the SHA-256 compression engine:
//   - K_TABLE   : the 64 round constants
//   - IV        : FIPS 180-4 initial hash value H0..H7
//   - N_ROUNDS_DEFAULT : rounds per chunk (64 in the product)
//   - state_t   : compression FSM encoding
//   - big_sigma0/big_sigma1/ch/maj : round helper functions
package sha256_pkg;

  localparam int N_ROUNDS_DEFAULT = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FOLD  = 2'd2
  } state_t;

  localparam logic [31:0] IV [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K_TABLE [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                     input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha256_k_rom.sv
// sha256_k_rom
// Combinational lookup of the SHA-256 round constant K[t].
// Ports:
//   addr  in   6   round index t
//   k     out  32  K[t]
module sha256_k_rom
  import sha256_pkg::*;
(
  input  logic [5:0]  addr,
  output logic [31:0] k
);

  assign k = K_TABLE[addr];

endmodule

// File: rtl/sha256_compress_round.sv
// sha256_compress_round
// SHA-256 compression engine. One round is executed per cycle in which a
// valid schedule word is presented; after N_ROUNDS rounds the working
// variables are folded into the chaining state H0..H7.
// Ports:
//   clk      in   1    clock, posedge
//   rst_n    in   1    asynchronous active-low reset
//   clear    in   1    synchronous abort back to idle (H kept)
//   init     in   1    load H with the IV (idle only)
//   start    in   1    begin a chunk, a..h <= H (idle only)
//   w_vld_i  in   1    w_i valid; one round consumed per valid cycle
//   w_i      in   32   schedule word W[t], t = round_o
//   busy     out  1    chunk in progress (ROUND or FOLD)
//   round_o  out  6    round index awaiting w_i, 0 when idle
//   done     out  1    one-cycle pulse after the fold
//   digest   out  256  {H0..H7}, H0 in the top word
module sha256_compress_round
  import sha256_pkg::*;
#(
  parameter int N_ROUNDS = N_ROUNDS_DEFAULT
)(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         init,
  input  logic         start,
  input  logic         w_vld_i,
  input  logic [31:0]  w_i,
  output logic         busy,
  output logic [5:0]   round_o,
  output logic         done,
  output logic [255:0] digest
);

  localparam logic [5:0] LAST_T = 6'(N_ROUNDS - 1);

  state_t      state_q, state_d;
  logic [5:0]  t_q;
  logic        done_q;
  logic [31:0] v_q [0:7];
  logic [31:0] h_q [0:7];
  logic [31:0] k_t;
  logic [31:0] t1, t2;

  sha256_k_rom u_k_rom (
    .addr (t_q),
    .k    (k_t)
  );

  // Single-cycle round function on the current working variables.
  always_comb begin
    t1 = v_q[7] + big_sigma1(v_q[4]) + ch(v_q[4], v_q[5], v_q[6]) + k_t + w_i;
    t2 = big_sigma0(v_q[0]) + maj(v_q[0], v_q[1], v_q[2]);
  end

  // Next-state logic; clear overrides every transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_ROUND;
      ST_ROUND: if (w_vld_i && (t_q == LAST_T)) state_d = ST_FOLD;
      ST_FOLD:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (clear) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Datapath: working variables, chaining state, round counter and done.
  // When init and start coincide, a..h take the IV directly since H is
  // only being loaded in that same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_q    <= '0;
      done_q <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        v_q[i] <= '0;
        h_q[i] <= IV[i];
      end
    end else if (clear) begin
      t_q    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state_q == ST_FOLD);
      case (state_q)
        ST_IDLE: begin
          if (init) begin
            for (int i = 0; i < 8; i++) h_q[i] <= IV[i];
          end
          if (start) begin
            t_q <= '0;
            for (int i = 0; i < 8; i++) v_q[i] <= init ? IV[i] : h_q[i];
          end
        end
        ST_ROUND: begin
          if (w_vld_i) begin
            v_q[7] <= v_q[6];
            v_q[6] <= v_q[5];
            v_q[5] <= v_q[4];
            v_q[4] <= v_q[3] + t1;
            v_q[3] <= v_q[2];
            v_q[2] <= v_q[1];
            v_q[1] <= v_q[0];
            v_q[0] <= t1 + t2;
            t_q    <= t_q + 6'd1;
          end
        end
        ST_FOLD: begin
          t_q <= '0;
          for (int i = 0; i < 8; i++) h_q[i] <= h_q[i] + v_q[i];
        end
        default: t_q <= '0;
      endcase
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign round_o = busy ? t_q : 6'd0;
  assign done    = done_q;
  assign digest  = {h_q[0], h_q[1], h_q[2], h_q[3], h_q[4], h_q[5], h_q[6], h_q[7]};

endmodule

// File: tb/tb_sha256_compress_round.sv
// tb_sha256_compress_round
// Directed bench for the SHA-256 compression engine. Message schedules are
// expanded from 16-word blocks here; digests are the published FIPS values.
module tb_sha256_compress_round;

  localparam logic [255:0] IV_DIGEST =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_DIGEST =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_DIGEST =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] TWO_DIGEST =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clear = 1'b0;
  logic         init = 1'b0;
  logic         start = 1'b0;
  logic         w_vld_i = 1'b0;
  logic [31:0]  w_i = '0;
  logic         busy;
  logic [5:0]   round_o;
  logic         done;
  logic [255:0] digest;

  logic [31:0] blk [0:15];
  logic [31:0] ws  [0:63];
  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sha256_compress_round dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .init    (init),
    .start   (start),
    .w_vld_i (w_vld_i),
    .w_i     (w_i),
    .busy    (busy),
    .round_o (round_o),
    .done    (done),
    .digest  (digest)
  );

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ss0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ss1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic expand;
    for (int t = 0; t < 16; t++) ws[t] = blk[t];
    for (int t = 16; t < 64; t++)
      ws[t] = ss1(ws[t-2]) + ws[t-7] + ss0(ws[t-15]) + ws[t-16];
  endtask

  task automatic set_abc;
    for (int i = 0; i < 16; i++) blk[i] = '0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
    expand();
  endtask

  // Runs one chunk. inj_kind: 0 none, 1 start+init at round inj_t,
  // 2 clear at round inj_t, 3 rst_n low at round inj_t.
  task automatic run_chunk(input bit do_init, input bit stall, input bit chk_stable,
                           input logic [255:0] h_prev, input int inj_t, input int inj_kind,
                           output int cycles, output bit got_done);
    int t_m;
    bit trk_ok;
    bit dig_ok;
    bit stop;
    logic [255:0] hp;
    hp = do_init ? IV_DIGEST : h_prev;
    init = do_init;
    start = 1'b1;
    w_vld_i = 1'b0;
    step();
    init = 1'b0;
    start = 1'b0;
    cycles = 1;
    t_m = 0;
    got_done = 1'b0;
    trk_ok = 1'b1;
    dig_ok = 1'b1;
    stop = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || round_o !== 6'd0)
      $display("[TB] FAIL start_busy: busy=%b round=%0d, required busy=1 round=0", busy, round_o);
    else n_pass++;
    while (!got_done && !stop && cycles < 400) begin
      w_vld_i = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      w_i = (t_m < 64) ? ws[t_m] : 32'hdeadbeef;
      if (inj_kind != 0 && t_m == inj_t) begin
        if (inj_kind == 1) begin
          start = 1'b1;
          init = 1'b1;
          w_vld_i = 1'b1;
        end else if (inj_kind == 2) begin
          clear = 1'b1;
          w_vld_i = 1'b1;
          stop = 1'b1;
        end else begin
          rst_n = 1'b0;
          #1;
          stop = 1'b1;
        end
      end
      if (!(stop && inj_kind == 3)) begin
        step();
        cycles++;
        start = 1'b0;
        init = 1'b0;
        if (!stop) begin
          if (w_vld_i && t_m < 64) t_m++;
          if (done) got_done = 1'b1;
          else begin
            if (t_m < 64 && (round_o !== 6'(t_m) || busy !== 1'b1)) trk_ok = 1'b0;
            if (chk_stable && digest !== hp) dig_ok = 1'b0;
          end
        end
      end
    end
    clear = 1'b0;
    w_vld_i = 1'b0;
    n_checks++;
    if (!trk_ok) $display("[TB] FAIL round_track: round_o/busy diverged from consumed-word count %0d", t_m);
    else n_pass++;
    if (chk_stable) begin
      n_checks++;
      if (!dig_ok) $display("[TB] FAIL digest_stable: digest=%h changed mid-chunk, required %h", digest, hp);
      else n_pass++;
    end
    if (got_done) begin
      step();
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0)
        $display("[TB] FAIL done_pulse: done=%b busy=%b after done, required 0 0", done, busy);
      else n_pass++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) step();
    n_checks++;
    if (digest !== IV_DIGEST) $display("[TB] FAIL reset_digest: got %h required %h", digest, IV_DIGEST);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || round_o !== 6'd0)
      $display("[TB] FAIL reset_ctrl: busy=%b done=%b round=%0d required 0 0 0", busy, done, round_o);
    else n_pass++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_abc;
    int cyc;
    bit ok;
    set_abc();
    run_chunk(1'b1, 1'b0, 1'b1, IV_DIGEST, -1, 0, cyc, ok);
    n_checks++;
    if (!ok || cyc !== 66) $display("[TB] FAIL abc_latency: done=%b after %0d cycles, required 1 after 66", ok, cyc);
    else n_pass++;
    n_checks++;
    if (digest !== ABC_DIGEST) $display("[TB] FAIL abc_digest: got %h required %h", digest, ABC_DIGEST);
    else n_pass++;
  endtask

  task automatic test_empty;
    int cyc;
    bit ok;
    for (int i = 0; i < 16; i++) blk[i] = '0;
    blk[0] = 32'h80000000;
    expand();
    run_chunk(1'b1, 1'b0, 1'b1, IV_DIGEST, -1, 0, cyc, ok);
    n_checks++;
    if (!ok || digest !== EMPTY_DIGEST) $display("[TB] FAIL empty_digest: got %h required %h", digest, EMPTY_DIGEST);
    else n_pass++;
  endtask

  task automatic test_two_block;
    int cyc;
    bit ok;
    blk = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
            32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
            32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
            32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    expand();
    run_chunk(1'b1, 1'b0, 1'b1, IV_DIGEST, -1, 0, cyc, ok);
    for (int i = 0; i < 16; i++) blk[i] = '0;
    blk[15] = 32'h000001c0;
    expand();
    run_chunk(1'b0, 1'b0, 1'b0, IV_DIGEST, -1, 0, cyc, ok);
    n_checks++;
    if (!ok || digest !== TWO_DIGEST) $display("[TB] FAIL two_block_digest: got %h required %h", digest, TWO_DIGEST);
    else n_pass++;
  endtask

  task automatic test_stall;
    int cyc;
    bit ok;
    set_abc();
    run_chunk(1'b1, 1'b1, 1'b1, IV_DIGEST, -1, 0, cyc, ok);
    n_checks++;
    if (!ok || digest !== ABC_DIGEST) $display("[TB] FAIL stall_digest: got %h required %h", digest, ABC_DIGEST);
    else n_pass++;
  endtask

  task automatic test_clear;
    int cyc;
    bit ok;
    set_abc();
    run_chunk(1'b1, 1'b0, 1'b1, IV_DIGEST, 30, 2, cyc, ok);
    n_checks++;
    if (busy !== 1'b0 || round_o !== 6'd0 || done !== 1'b0)
      $display("[TB] FAIL clear_ctrl: busy=%b round=%0d done=%b required 0 0 0", busy, round_o, done);
    else n_pass++;
    n_checks++;
    if (digest !== IV_DIGEST) $display("[TB] FAIL clear_keeps_h: got %h required %h", digest, IV_DIGEST);
    else n_pass++;
    clear = 1'b1;
    start = 1'b1;
    step();
    clear = 1'b0;
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b0) $display("[TB] FAIL clear_beats_start: busy=%b required 0", busy);
    else n_pass++;
    run_chunk(1'b1, 1'b0, 1'b1, IV_DIGEST, -1, 0, cyc, ok);
    n_checks++;
    if (!ok || digest !== ABC_DIGEST) $display("[TB] FAIL clear_rerun: got %h required %h", digest, ABC_DIGEST);
    else n_pass++;
  endtask

  task automatic test_ignore_start;
    int cyc;
    bit ok;
    set_abc();
    run_chunk(1'b1, 1'b0, 1'b1, IV_DIGEST, 10, 1, cyc, ok);
    n_checks++;
    if (!ok || cyc !== 66 || digest !== ABC_DIGEST)
      $display("[TB] FAIL start_while_busy: cycles=%0d digest=%h required 66 %h", cyc, digest, ABC_DIGEST);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    int cyc;
    bit ok;
    set_abc();
    run_chunk(1'b0, 1'b0, 1'b1, ABC_DIGEST, 20, 3, cyc, ok);
    n_checks++;
    if (busy !== 1'b0 || round_o !== 6'd0 || digest !== IV_DIGEST)
      $display("[TB] FAIL reset_mid: busy=%b round=%0d digest=%h required 0 0 %h", busy, round_o, digest, IV_DIGEST);
    else n_pass++;
    step();
    rst_n = 1'b1;
    repeat (2) step();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("[TB] FAIL reset_release: busy=%b done=%b required 0 0", busy, done);
    else n_pass++;
  endtask

  task automatic test_init_only;
    int cyc;
    bit ok;
    set_abc();
    run_chunk(1'b1, 1'b0, 1'b1, IV_DIGEST, -1, 0, cyc, ok);
    init = 1'b1;
    step();
    init = 1'b0;
    n_checks++;
    if (digest !== IV_DIGEST || busy !== 1'b0)
      $display("[TB] FAIL init_only: digest=%h busy=%b required %h 0", digest, busy, IV_DIGEST);
    else n_pass++;
  endtask

  initial begin
    $display("[TB] sha256_compress_round bench starting");
    test_reset();
    test_abc();
    test_empty();
    test_two_block();
    test_stall();
    test_clear();
    test_ignore_start();
    test_reset_mid();
    test_init_only();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
